// File: rtl/lfsr_rms_sampler_if.sv
// ============================================================================
//  Module      : lfsr_rms_sampler_if
//  Description : Sample/control bundle between the abs stage and the RMS
//                sampler. The master drives the packed samples and select
//                controls. The slave (the sampler) returns the chosen sample,
//                its index and a valid strobe.
//  Signals     : in_i      NSAMP*NBITS  packed samples, sample k at [NBITS*k +: NBITS]
//                en_i      1            advance/sample enable
//                sync_i    1            restart select sequence (level)
//                mode_i    2            00/11 LFSR, 01 sequential, 10 fixed
//                fix_sel_i SELW         index used in fixed mode
//                out_o     NBITS        selected sample (registered)
//                sel_o     SELW         index that produced out_o
//                valid_o   1            out_o/sel_o carry a new sample
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_rms_sampler_if #(
    parameter int NSAMP = 8,
    parameter int NBITS = 4
);
    localparam int SELW = $clog2(NSAMP);

    logic [NSAMP*NBITS-1:0] in_i;
    logic                   en_i;
    logic                   sync_i;
    logic [1:0]             mode_i;
    logic [SELW-1:0]        fix_sel_i;
    logic [NBITS-1:0]       out_o;
    logic [SELW-1:0]        sel_o;
    logic                   valid_o;

    modport master (
        output in_i, en_i, sync_i, mode_i, fix_sel_i,
        input  out_o, sel_o, valid_o
    );

    modport slave (
        input  in_i, en_i, sync_i, mode_i, fix_sel_i,
        output out_o, sel_o, valid_o
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_rms_sampler.sv
// ============================================================================
//  Module      : lfsr_rms_sampler
//  Description : Decimating mux that picks one of NSAMP abs-valued samples per
//                enabled clock for the downstream RMS accumulator. The index
//                comes from a Fibonacci LFSR (advanced SELW steps per clock),
//                a wrapping counter, or a fixed runtime value.
//  Ports       : clk_i  clock
//                rst_i  synchronous active-high reset
//                bus    lfsr_rms_sampler_if slave modport (samples, controls,
//                       selected sample, index and valid strobe)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_rms_sampler #(
    parameter int NSAMP    = 8,
    parameter int NBITS    = 4,
    parameter int LFSR_LEN = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    lfsr_rms_sampler_if.slave  bus
);

    localparam int SELW = $clog2(NSAMP);

    // Feedback tap position for each supported length (maximal-length taps).
    localparam int c_TAP = (LFSR_LEN == 7)  ? 6 :
                           (LFSR_LEN == 9)  ? 5 :
                           (LFSR_LEN == 11) ? 9 : 14;

    localparam logic [LFSR_LEN-1:0] c_SEED = {LFSR_LEN{1'b1}};

    localparam logic [1:0] c_MODE_SEQ = 2'b01;
    localparam logic [1:0] c_MODE_FIX = 2'b10;

    generate
        if (!(LFSR_LEN == 7 || LFSR_LEN == 9 || LFSR_LEN == 11 || LFSR_LEN == 15)) begin : g_bad_lfsr_len
            $error("lfsr_rms_sampler: LFSR_LEN must be 7, 9, 11 or 15");
        end
        if (NSAMP < 2 || NSAMP > 16 || (NSAMP & (NSAMP - 1)) != 0) begin : g_bad_nsamp
            $error("lfsr_rms_sampler: NSAMP must be a power of 2 in 2..16");
        end
        if ($bits(bus.in_i) != NSAMP*NBITS || $bits(bus.out_o) != NBITS) begin : g_bad_if
            $error("lfsr_rms_sampler: interface parameters do not match the sampler");
        end
    endgenerate

    logic [LFSR_LEN-1:0] r_lfsr;
    logic [SELW-1:0]     r_cnt;
    logic [NBITS-1:0]    r_out;
    logic [SELW-1:0]     r_sel;
    logic                r_valid;

    logic [LFSR_LEN-1:0] w_lfsr_next;
    logic [SELW-1:0]     w_sel;
    logic [NBITS-1:0]    w_sample;

    // SELW single steps unrolled into one clock so each enabled cycle consumes
    // a fresh, non-overlapping SELW-bit window of the sequence.
    always_comb begin
        w_lfsr_next = r_lfsr;
        for (int i = 0; i < SELW; i++) begin
            w_lfsr_next = {w_lfsr_next[LFSR_LEN-2:0],
                           w_lfsr_next[LFSR_LEN-1] ^ w_lfsr_next[c_TAP-1]};
        end
    end

    // Mode 11 is a reserved alias of LFSR mode and falls into the default arm.
    always_comb begin
        case (bus.mode_i)
            c_MODE_SEQ: w_sel = r_cnt;
            c_MODE_FIX: w_sel = bus.fix_sel_i;
            default:    w_sel = r_lfsr[SELW-1:0];
        endcase
    end

    assign w_sample = bus.in_i[NBITS*w_sel +: NBITS];

    // Output capture: uses the current (pre-sync) index even when sync_i is
    // high in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else if (bus.en_i) begin
            r_out   <= w_sample;
            r_sel   <= w_sel;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Index state: both sources free-run in every mode so switching modes
    // resumes their sequences. NSAMP is a power of 2, so the counter wraps
    // from NSAMP-1 to 0 on natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.sync_i) begin
            r_lfsr <= c_SEED;
            r_cnt  <= '0;
        end else if (bus.en_i) begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= r_cnt + SELW'(1);
        end
    end

    assign bus.out_o   = r_out;
    assign bus.sel_o   = r_sel;
    assign bus.valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rms_sampler.sv
// ============================================================================
//  Module      : tb_lfsr_rms_sampler
//  Description : Self-checking bench for lfsr_rms_sampler. Two instances run
//                side by side: default parameters (8 x 4-bit, LFSR 7) and
//                16 x 6-bit with LFSR 11. A bit-stream model of the select
//                sequence predicts every output each cycle; directed steps
//                pin literal values taken from hand calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_rms_sampler;

    localparam int NA = 8,  BA = 4, LA = 7,  TA = 6, SA = 3;
    localparam int NB = 16, BB = 6, LB = 11, TB = 9, SB = 4;

    typedef bit bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    lfsr_rms_sampler_if #(.NSAMP(NA), .NBITS(BA)) bus_a();
    lfsr_rms_sampler_if #(.NSAMP(NB), .NBITS(BB)) bus_b();

    lfsr_rms_sampler #(.NSAMP(NA), .NBITS(BA), .LFSR_LEN(LA)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    lfsr_rms_sampler #(.NSAMP(NB), .NBITS(BB), .LFSR_LEN(LB)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---- model: the LFSR as a bit stream b[n] = b[n-L] ^ b[n-T] ----------
    // Queue holds the last L bits, oldest first; the newest bit is the index LSB.
    function automatic bq_t seed(input int l);
        bq_t q;
        for (int i = 0; i < l; i++) q.push_back(1'b1);
        return q;
    endfunction

    function automatic bq_t adv(input bq_t q, input int t, input int n);
        bq_t r = q;
        for (int i = 0; i < n; i++) begin
            r.push_back(r[0] ^ r[r.size() - t]);
            void'(r.pop_front());
        end
        return r;
    endfunction

    function automatic int pick(input bq_t q, input int cnt, input logic [1:0] mode,
                                input int fix, input int w);
        int v = 0;
        if (mode == 2'b01) return cnt;
        if (mode == 2'b10) return fix;
        for (int j = 0; j < w; j++) v |= int'(q[q.size() - 1 - j]) << j;
        return v;
    endfunction

    // ---- compare process: check previous prediction, then predict next edge
    initial begin
        bq_t qa, qb;
        int  ca = 0, cb = 0, s;
        int  ea_out = 0, ea_sel = 0, ea_val = 0;
        int  eb_out = 0, eb_sel = 0, eb_val = 0;
        bit  have = 1'b0;
        qa = seed(LA);
        qb = seed(LB);
        forever begin
            @(negedge clk);
            if (have) begin
                chk("a_valid", bus_a.valid_o, ea_val);
                chk("a_sel",   bus_a.sel_o,   ea_sel);
                chk("a_out",   bus_a.out_o,   ea_out);
                chk("b_valid", bus_b.valid_o, eb_val);
                chk("b_sel",   bus_b.sel_o,   eb_sel);
                chk("b_out",   bus_b.out_o,   eb_out);
            end
            if (rst) begin
                qa = seed(LA); ca = 0; ea_out = 0; ea_sel = 0; ea_val = 0;
                qb = seed(LB); cb = 0; eb_out = 0; eb_sel = 0; eb_val = 0;
                have = 1'b1;
            end else begin
                s = pick(qa, ca, bus_a.mode_i, int'(bus_a.fix_sel_i), SA);
                ea_val = int'(bus_a.en_i);
                if (bus_a.en_i) begin
                    ea_out = int'(bus_a.in_i[BA*s +: BA]);
                    ea_sel = s;
                end
                if (bus_a.sync_i) begin qa = seed(LA); ca = 0; end
                else if (bus_a.en_i) begin qa = adv(qa, TA, SA); ca = (ca + 1) % NA; end

                s = pick(qb, cb, bus_b.mode_i, int'(bus_b.fix_sel_i), SB);
                eb_val = int'(bus_b.en_i);
                if (bus_b.en_i) begin
                    eb_out = int'(bus_b.in_i[BB*s +: BB]);
                    eb_sel = s;
                end
                if (bus_b.sync_i) begin qb = seed(LB); cb = 0; end
                else if (bus_b.en_i) begin qb = adv(qb, TB, SB); cb = (cb + 1) % NB; end
            end
        end
    end

    // ---- directed stimulus with literal expectations ---------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ident_a();
        for (int k = 0; k < NA; k++) bus_a.in_i[BA*k +: BA] = BA'(k);
    endtask

    initial begin
        int hist[NA];
        int early;
        logic [2:0] seq_en  [4] = '{1, 0, 1, 1};
        int         seq_sel [4] = '{0, 0, 1, 2};

        bus_a.en_i = 1'b0; bus_a.sync_i = 1'b0; bus_a.mode_i = 2'b00; bus_a.fix_sel_i = '0;
        bus_b.en_i = 1'b0; bus_b.sync_i = 1'b0; bus_b.mode_i = 2'b00; bus_b.fix_sel_i = '0;
        bus_b.in_i = '0;
        ident_a();
        rst = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_out",   bus_a.out_o,   0);
        chk("rst_sel",   bus_a.sel_o,   0);
        chk("rst_valid", bus_a.valid_o, 0);
        chk("rst_lfsr",  dut_a.r_lfsr,  'h7F);

        // 1: LFSR sequence 7, 0, 0, 4 with states 78, 40, 04
        rst = 1'b0;
        bus_a.en_i = 1'b1;
        tick(); chk("t1_sel0", bus_a.sel_o, 7); chk("t1_out0", bus_a.out_o, 7); chk("t1_lfsr1", dut_a.r_lfsr, 'h78);
        tick(); chk("t1_sel1", bus_a.sel_o, 0); chk("t1_lfsr2", dut_a.r_lfsr, 'h40);
        tick(); chk("t1_sel2", bus_a.sel_o, 0); chk("t1_lfsr3", dut_a.r_lfsr, 'h04);
        tick(); chk("t1_sel3", bus_a.sel_o, 4); chk("t1_out3", bus_a.out_o, 4);

        // 2: period 127 and index histogram
        bus_a.sync_i = 1'b1;
        tick(); chk("t2_sync_lfsr", dut_a.r_lfsr, 'h7F);
        bus_a.sync_i = 1'b0;
        foreach (hist[k]) hist[k] = 0;
        early = 0;
        for (int i = 1; i <= 127; i++) begin
            bus_a.in_i = BA*NA'($urandom);
            tick();
            hist[bus_a.sel_o]++;
            if (i < 127 && dut_a.r_lfsr == 7'h7F) early++;
        end
        chk("t2_period", dut_a.r_lfsr, 'h7F);
        chk("t2_early",  early, 0);
        for (int k = 0; k < NA; k++) chk("t2_hist", (hist[k] == 15 || hist[k] == 16), 1);

        // 3: sequential mode with en toggling, then sync at cnt=5
        ident_a();
        bus_a.mode_i = 2'b01; bus_a.sync_i = 1'b1; bus_a.en_i = 1'b1;
        tick();
        bus_a.sync_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.en_i = seq_en[i][0];
            tick();
            chk("t3_sel",   bus_a.sel_o,   seq_sel[i]);
            chk("t3_valid", bus_a.valid_o, seq_en[i][0]);
        end
        bus_a.en_i = 1'b1;
        tick(); tick();
        bus_a.sync_i = 1'b1;
        tick(); chk("t3_sync_sel", bus_a.sel_o, 5);
        bus_a.sync_i = 1'b0;
        tick(); chk("t3_post_sel", bus_a.sel_o, 0);

        // Reserved mode 11 behaves as LFSR: first post-sync index is NSAMP-1
        bus_a.mode_i = 2'b11; bus_a.sync_i = 1'b1;
        tick();
        bus_a.sync_i = 1'b0;
        tick(); chk("alias_sel", bus_a.sel_o, 7);

        // 4: fixed mode
        bus_a.mode_i = 2'b10; bus_a.fix_sel_i = 3'd3;
        bus_a.in_i[BA*3 +: BA] = 4'hA;
        tick(); chk("t4_out", bus_a.out_o, 'hA); chk("t4_valid", bus_a.valid_o, 1);
        tick(); chk("t4_out2", bus_a.out_o, 'hA);
        bus_a.fix_sel_i = 3'd6;
        tick(); chk("t4_out6", bus_a.out_o, 6); chk("t4_sel6", bus_a.sel_o, 6);

        // 5: reset mid-stream wins over en and sync
        bus_a.mode_i = 2'b00; bus_a.sync_i = 1'b1; rst = 1'b1;
        tick();
        chk("t5_out", bus_a.out_o, 0); chk("t5_sel", bus_a.sel_o, 0); chk("t5_valid", bus_a.valid_o, 0);
        rst = 1'b0; bus_a.sync_i = 1'b0;
        tick(); chk("t5_first_sel", bus_a.sel_o, 7); chk("t5_first_out", bus_a.out_o, 7);
        bus_a.en_i = 1'b0;

        // 6: wide instance, 2047-clock period with random samples
        bus_b.mode_i = 2'b00; bus_b.en_i = 1'b1; bus_b.sync_i = 1'b1;
        tick();
        bus_b.sync_i = 1'b0;
        early = 0;
        for (int i = 1; i <= 2047; i++) begin
            bus_b.in_i = {$urandom, $urandom, $urandom};
            tick();
            if (i < 2047 && dut_b.r_lfsr == 11'h7FF) early++;
        end
        chk("t6_period", dut_b.r_lfsr, 'h7FF);
        chk("t6_early",  early, 0);
        bus_b.en_i = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lfsr_rms_sampler.md
Name: lfsr_rms_sampler

Overview:
- Parametrised successor to the AGC's 8:1 LFSR RMS decimating mux. It selects one of NSAMP abs-valued samples per clock to feed the downstream RMS accumulator.
- Adds configurable sample count, sample width and LFSR length. Three runtime select modes: pseudo-random, sequential and fixed.
- Adds a clock enable, a valid strobe and reporting of the chosen index for diagnostics.
- Sits between the per-channel abs stage and the RMS square/accumulate stage.

Parameters:
NSAMP, 8, samples per clock on in_i; power of 2, 2..16.
NBITS, 4, bits per sample (already abs-ed, unsigned).
LFSR_LEN, 7, LFSR length; legal values 7, 9, 11, 15 only (elaboration error otherwise).
SELW, $clog2(NSAMP), derived; index width (localparam, not overridable).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
in_i  in  NSAMP*NBITS  samples; sample k = in_i[NBITS*k +: NBITS]
en_i  in  1  advance/sample enable
sync_i  in  1  restart select sequence (level; acts every cycle it is high)
mode_i  in  2  00 = LFSR, 01 = sequential, 10 = fixed, 11 = LFSR (reserved alias)
fix_sel_i  in  SELW  index used in fixed mode
out_o  out  NBITS  selected sample (registered)
sel_o  out  SELW  index that produced out_o (registered, aligned with out_o)
valid_o  out  1  out_o/sel_o hold a new sample this cycle

Behaviour:
- State registers:
  - lfsr[LFSR_LEN-1:0], seed all-ones.
  - cnt[SELW-1:0].
- LFSR single step, Fibonacci shift-left:
  - fb = lfsr[L-1] ^ lfsr[T-1]; next = {lfsr[L-2:0], fb}.
  - Tap T per length: 7→6, 9→5, 11→9, 15→14.
- Per enabled clock the LFSR applies SELW single steps in one cycle (unrolled). Every produced bit is used; state period is 2^L-1 clocks whenever gcd(SELW, 2^L-1) = 1.
- Current index sel (combinational from state):
  - LFSR mode: lfsr[SELW-1:0].
  - Sequential mode: cnt.
  - Fixed mode: fix_sel_i.
- Reset (rst_i high at clk edge):
  - lfsr <= all-ones, cnt <= 0.
  - out_o <= 0, sel_o <= 0, valid_o <= 0.
  - Reset has priority over every other input, and is legal mid-stream.
- Normal clock (no reset):
  - If en_i: out_o <= sample[sel], sel_o <= sel, valid_o <= 1.
  - Else: out_o and sel_o hold, valid_o <= 0.
- State advance:
  - If sync_i: lfsr <= all-ones, cnt <= 0. Applies regardless of en_i.
  - Else if en_i: lfsr <= SELW-step value; cnt <= cnt+1, wrapping at NSAMP-1 → 0.
  - Else: hold.
- sync_i and en_i together: the sample is still captured using the pre-sync sel; state reloads. The first post-sync index is therefore NSAMP-1 (LFSR) or 0 (sequential).
- Latency: in_i at edge n → out_o/sel_o/valid_o visible after edge n (1 cycle).
- Mode changes take effect on the same edge's capture, since sel is combinational from mode_i. Both lfsr and cnt advance in every mode, so switching back resumes their free-running values.
- fix_sel_i is always in range because NSAMP is a power of 2.
- No other outputs; no X propagation from unused modes.

Test Plan:
1. Defaults, reset then en_i=1 continuous, mode=00, in_i sample k = k → out_o/sel_o = 7, 0, 0, 4, ... on successive cycles; lfsr states 0x7F, 0x78, 0x40, 0x04.
2. Defaults, mode=00, en_i=1 for 127 clocks after sync → lfsr back to 0x7F exactly at clock 127, not earlier. The 127-cycle sel_o histogram has counts 15 or 16 per index, and every index appears.
3. mode=01, en_i toggling 1,0,1,1 → sel_o 0, (hold 0, valid_o 0), 1, 2. sync_i pulsed with en_i=1 at cnt=5 → that cycle sel_o=5, next sel_o=0.
4. mode=10, fix_sel_i=3, in_i sample 3 = 0xA → out_o=0xA, valid_o=1 every enabled cycle. Change fix_sel_i to 6 → next output is sample 6.
5. rst_i asserted mid-stream with en_i=1, sync_i=1 → next cycle out_o=0, sel_o=0, valid_o=0. The first enabled cycle after release yields sel_o=NSAMP-1 in LFSR mode.
6. NSAMP=16, NBITS=6, LFSR_LEN=11: 2047 enabled clocks after sync → lfsr returns to 0x7FF. out_o equals in_i[6*sel_o +: 6] on every valid cycle (scoreboard).
